// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract controller: FSM state encodings and width helpers.
// Optional build macro SERIAL_SUB_SAT_EN is consumed by serial_sub_ctrl.sv.
package serial_sub_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit-index counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub_cell.sv
// One-bit full subtractor (x - y - bin) built from two cascaded half-subtractor stages.
// Purely combinational; the controller instantiates exactly one.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First stage subtracts y from x, second stage subtracts the incoming borrow.
  always_comb begin
    hs1_d = x ^ y;
    hs1_b = ~x & y;
    d     = hs1_d ^ bin;
    hs2_b = ~hs1_d & bin;
    bout  = hs1_b | hs2_b;
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b, LSB first, one bit per clock via full_sub_cell.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero when the final borrow is set.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_diff;
  logic             borrow_q;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  full_sub_cell u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic, handshake outputs and the shifted result word.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = (count == LAST_IDX);
    res_next   = (res_sr >> 1) | {cell_d, {(WIDTH-1){1'b0}}};
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SERIAL_SUB_SAT_EN
  // A negative result is clamped to zero; the borrow still flags it.
  always_comb begin
    final_diff = cell_bout ? '0 : res_next;
  end
`else
  always_comb begin
    final_diff = res_next;
  end
`endif

  // Datapath and state register; diff/borrow only change on the final bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sr     <= a;
        b_sr     <= b;
        count    <= '0;
        borrow_q <= 1'b0;
      end else if (state == ST_RUN) begin
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        res_sr   <= res_next;
        borrow_q <= cell_bout;
        count    <= last_bit ? '0 : count + 1'b1;
        if (last_bit) begin
          diff   <= final_diff;
          borrow <= cell_bout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and held-start random checks for serial_sub_ctrl at WIDTH=8 and WIDTH=13.
// Expected results honour SERIAL_SUB_SAT_EN when it is defined for the build.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wrap_diff;
    logic       borrow;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start13;
  logic [7:0]  a8, b8, diff8;
  logic [12:0] a13, b13, diff13;
  logic        busy8, done8, borrow8;
  logic        busy13, done13, borrow13;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_sub_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow(borrow13)
  );

  function automatic logic [31:0] expDiff(input logic [31:0] wrap, input logic bw);
`ifdef SERIAL_SUB_SAT_EN
    return bw ? 32'h0 : wrap;
`else
    return wrap;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting for done", name);
  endtask

  // One start pulse on the 8-bit DUT; returns cycles to done and busy-high cycle count.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               output int lat, output int busy_cycles);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_cycles = busy8 ? 1 : 0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) busy_cycles++;
    end
    @(posedge clk); #1;
    if (busy8) busy_cycles++;
    checkOutput("done_single_pulse", {31'b0, done8}, 32'h0);
  endtask

  task automatic setIn(input int w, input logic [31:0] av, input logic [31:0] bv, input logic st);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; start8 = st;
    end else begin
      a13 = av[12:0]; b13 = bv[12:0]; start13 = st;
    end
  endtask

  // Start held high: back-to-back ops, checked against a - b and done spacing of w+2.
  task automatic runHeld(input int w, input int ops);
    logic [31:0] av, bv, mask, got_d;
    logic        got_b, dn, exp_b;
    int          waited;
    mask = (w == 8) ? 32'hFF : 32'h1FFF;
    av = $urandom & mask;
    bv = $urandom & mask;
    @(negedge clk);
    setIn(w, av, bv, 1'b1);
    for (int i = 0; i < ops; i++) begin
      waited = 0;
      dn = 1'b0;
      while (!dn && waited < 100) begin
        @(posedge clk); #1;
        waited++;
        dn = (w == 8) ? done8 : done13;
      end
      if (!dn) begin
        timeoutFail("held_done");
        break;
      end
      got_d = (w == 8) ? {24'b0, diff8} : {19'b0, diff13};
      got_b = (w == 8) ? borrow8 : borrow13;
      exp_b = (av < bv);
      checkOutput("held_diff", got_d, expDiff((av - bv) & mask, exp_b));
      checkOutput("held_borrow", {31'b0, got_b}, {31'b0, exp_b});
      if (i > 0) checkOutput("held_spacing", waited, w + 2);
      av = $urandom & mask;
      bv = $urandom & mask;
      setIn(w, av, bv, 1'b1);
    end
    setIn(w, 32'h0, 32'h0, 1'b0);
    repeat (w + 4) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   lat, bc, pulses, first_at;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1};
    vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start13 = 1'b0; a13 = '0; b13 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy8}, 32'h0);
    checkOutput("reset_done", {31'b0, done8}, 32'h0);
    checkOutput("reset_diff", {24'b0, diff8}, 32'h0);
    checkOutput("reset_borrow", {31'b0, borrow8}, 32'h0);
    checkOutput("reset_busy13", {31'b0, busy13}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, bc);
      checkOutput("vec_diff", {24'b0, diff8},
                  expDiff({24'b0, vecs[i].wrap_diff}, vecs[i].borrow));
      checkOutput("vec_borrow", {31'b0, borrow8}, {31'b0, vecs[i].borrow});
      checkOutput("vec_latency", lat, 8);
      checkOutput("vec_busy_cycles", bc, 9);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_hold_diff", {24'b0, diff8}, expDiff(32'h80, 1'b1));
    checkOutput("idle_hold_borrow", {31'b0, borrow8}, 32'h1);

    // Start pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("midrun_old_diff_held", {24'b0, diff8}, expDiff(32'h80, 1'b1));
    pulses = 0;
    first_at = -1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        if (first_at < 0) first_at = j;
      end
    end
    checkOutput("midrun_pulses", pulses, 1);
    checkOutput("midrun_done_time", first_at, 3);
    checkOutput("midrun_diff", {24'b0, diff8}, 32'h1E);
    checkOutput("midrun_borrow", {31'b0, borrow8}, 32'h0);

    // Reset during the fourth RUN cycle aborts the op with no done pulse.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_busy", {31'b0, busy8}, 32'h0);
    checkOutput("abort_done", {31'b0, done8}, 32'h0);
    checkOutput("abort_diff", {24'b0, diff8}, 32'h0);
    checkOutput("abort_borrow", {31'b0, borrow8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);
    applyStimulus(8'h5A, 8'h3C, lat, bc);
    checkOutput("post_abort_diff", {24'b0, diff8}, 32'h1E);
    checkOutput("post_abort_borrow", {31'b0, borrow8}, 32'h0);
    checkOutput("post_abort_latency", lat, 8);

    runHeld(8, 200);
    runHeld(13, 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
